reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_sequencer_sync_2ff.sv | 26 ++
 rtl/reset_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the PLL bring-up / staggered reset sequencer:
// state encoding, lock-loss counter width and a counter-width helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int               LLC_W   = 8;
   localparam logic [LLC_W-1:0] LLC_MAX = 8'hFF;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous clear, for any
// asynchronous level input entering the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// PLL reset / lock-debounce controller that releases NUM_DOMAINS downstream
// resets one after another and re-sequences on lock loss, timeout or request.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = 4,
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_FILTER    = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STAGE_DELAY    = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   sw_reset_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   all_ready,
   output logic [1:0]             seq_state,
   output logic [LLC_W-1:0]       lock_loss_count
);

   localparam int PR_W   = cnt_width(PLL_RST_CYCLES);
   localparam int FILT_W = cnt_width(LOCK_FILTER);
   localparam int TO_W   = cnt_width(LOCK_TIMEOUT);
   localparam int ST_W   = cnt_width(STAGE_DELAY);
   localparam int IDX_W  = cnt_width(NUM_DOMAINS);

   localparam logic [PR_W-1:0]   PR_LAST   = PR_W'(PLL_RST_CYCLES - 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0]   ST_LAST   = ST_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

   seq_state_t             state_q, state_d;
   logic [PR_W-1:0]        pr_cnt_q, pr_cnt_d;
   logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic [ST_W-1:0]        stage_cnt_q, stage_cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   pll_rst_q, pll_rst_d;
   logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
   logic                   all_ready_q, all_ready_d;
   logic [LLC_W-1:0]       llc_q, llc_d;

   logic lock_s;
   logic lock_lost_s;
   logic sw_req_s;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked),
      .q_o (lock_s)
   );

   // A request arriving during the PLL pulse must not stretch it, so it is masked there.
   assign sw_req_s    = sw_reset_req && (state_q != PLL_RST);
   assign lock_lost_s = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PLL_RST;
         pr_cnt_q     <= {PR_W{1'b0}};
         filt_cnt_q   <= {FILT_W{1'b0}};
         to_cnt_q     <= {TO_W{1'b0}};
         stage_cnt_q  <= {ST_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         pll_rst_q    <= 1'b1;
         domain_rst_q <= {NUM_DOMAINS{1'b1}};
         all_ready_q  <= 1'b0;
         llc_q        <= {LLC_W{1'b0}};
      end else begin
         state_q      <= state_d;
         pr_cnt_q     <= pr_cnt_d;
         filt_cnt_q   <= filt_cnt_d;
         to_cnt_q     <= to_cnt_d;
         stage_cnt_q  <= stage_cnt_d;
         idx_q        <= idx_d;
         pll_rst_q    <= pll_rst_d;
         domain_rst_q <= domain_rst_d;
         all_ready_q  <= all_ready_d;
         llc_q        <= llc_d;
      end
   end

   // Next-state: software request beats lock loss; a completing filter beats the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PLL_RST: begin
            if (pr_cnt_q == PR_LAST) state_d = WAIT_LOCK;
            else                     state_d = PLL_RST;
         end
         WAIT_LOCK: begin
            if (sw_req_s)                                state_d = PLL_RST;
            else if (lock_s && (filt_cnt_q == FILT_LAST)) state_d = RELEASE;
            else if (to_cnt_q == TO_LAST)                state_d = PLL_RST;
            else                                         state_d = WAIT_LOCK;
         end
         RELEASE: begin
            if (sw_req_s)                                          state_d = PLL_RST;
            else if (lock_lost_s)                                  state_d = WAIT_LOCK;
            else if ((idx_q == IDX_LAST) && (stage_cnt_q == ST_LAST)) state_d = RUN;
            else                                                   state_d = RELEASE;
         end
         RUN: begin
            if (sw_req_s)         state_d = PLL_RST;
            else if (lock_lost_s) state_d = WAIT_LOCK;
            else                  state_d = RUN;
         end
         default: state_d = PLL_RST;
      endcase
   end

   // Counters and registered outputs, derived from the state being entered next.
   always_comb begin
      pr_cnt_d     = {PR_W{1'b0}};
      filt_cnt_d   = {FILT_W{1'b0}};
      to_cnt_d     = {TO_W{1'b0}};
      stage_cnt_d  = {ST_W{1'b0}};
      idx_d        = {IDX_W{1'b0}};
      pll_rst_d    = 1'b1;
      domain_rst_d = {NUM_DOMAINS{1'b1}};
      all_ready_d  = 1'b0;
      llc_d        = llc_q;

      // Counters only advance while the state holds; any transition leaves them cleared.
      if (state_d == state_q) begin
         case (state_q)
            PLL_RST: pr_cnt_d = pr_cnt_q + PR_W'(1);
            WAIT_LOCK: begin
               if (lock_s) filt_cnt_d = filt_cnt_q + FILT_W'(1);
               else        filt_cnt_d = {FILT_W{1'b0}};
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
            RELEASE: begin
               if (stage_cnt_q == ST_LAST) begin
                  stage_cnt_d = {ST_W{1'b0}};
                  idx_d       = idx_q + IDX_W'(1);
               end else begin
                  stage_cnt_d = stage_cnt_q + ST_W'(1);
                  idx_d       = idx_q;
               end
            end
            default: idx_d = {IDX_W{1'b0}};
         endcase
      end else begin
         idx_d = {IDX_W{1'b0}};
      end

      case (state_d)
         PLL_RST: begin
            pll_rst_d    = 1'b1;
            domain_rst_d = {NUM_DOMAINS{1'b1}};
         end
         WAIT_LOCK: begin
            pll_rst_d    = 1'b0;
            domain_rst_d = {NUM_DOMAINS{1'b1}};
         end
         RELEASE: begin
            pll_rst_d = 1'b0;
            if (state_q != RELEASE) begin
               domain_rst_d    = {NUM_DOMAINS{1'b1}};
               domain_rst_d[0] = 1'b0;
            end else if (stage_cnt_q == ST_LAST) begin
               domain_rst_d = domain_rst_q;
               for (int k = 1; k < NUM_DOMAINS; k++) begin
                  if (k == int'(idx_q) + 1) domain_rst_d[k] = 1'b0;
                  else                      domain_rst_d[k] = domain_rst_q[k];
               end
            end else begin
               domain_rst_d = domain_rst_q;
            end
         end
         RUN: begin
            pll_rst_d    = 1'b0;
            domain_rst_d = {NUM_DOMAINS{1'b0}};
            all_ready_d  = 1'b1;
         end
         default: begin
            pll_rst_d    = 1'b1;
            domain_rst_d = {NUM_DOMAINS{1'b1}};
         end
      endcase

      if (lock_lost_s && !sw_req_s && (llc_q != LLC_MAX)) llc_d = llc_q + 8'd1;
      else                                               llc_d = llc_q;
   end

   assign pll_rst         = pll_rst_q;
   assign domain_rst      = domain_rst_q;
   assign all_ready       = all_ready_q;
   assign seq_state       = state_q;
   assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a time-in-phase model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_reset_sequencer;

   localparam int ND = 3;
   localparam int PR = 3;
   localparam int LF = 4;
   localparam int SD = 5;
   localparam int LT = 50;

   logic          clk          = 1'b0;
   logic          rst          = 1'b1;
   logic          pll_locked   = 1'b0;
   logic          sw_reset_req = 1'b0;
   logic          pll_rst;
   logic [ND-1:0] domain_rst;
   logic          all_ready;
   logic [1:0]    seq_state;
   logic [7:0]    lock_loss_count;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   reset_sequencer #(
      .NUM_DOMAINS    (ND),
      .PLL_RST_CYCLES (PR),
      .LOCK_FILTER    (LF),
      .LOCK_TIMEOUT   (LT),
      .STAGE_DELAY    (SD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .sw_reset_req    (sw_reset_req),
      .pll_rst         (pll_rst),
      .domain_rst      (domain_rst),
      .all_ready       (all_ready),
      .seq_state       (seq_state),
      .lock_loss_count (lock_loss_count)
   );

   always #5 clk = ~clk;

   // Model: phase, cycles spent in the phase, consecutive synced-lock run, loss count.
   int   m_phase = 0;
   int   m_since = 0;
   int   m_run   = 0;
   int   m_llc   = 0;
   logic m_s1    = 1'b0;
   logic m_s2    = 1'b0;

   task automatic enter(input int p);
      m_phase = p;
      m_since = 0;
      m_run   = 0;
   endtask

   task automatic model_step();
      logic ls;
      ls = m_s2;
      if (rst) begin
         enter(0);
         m_llc = 0;
         m_s1  = 1'b0;
         m_s2  = 1'b0;
      end else begin
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (m_phase == 0) begin
            if (m_since == PR - 1) enter(1);
            else m_since++;
         end else if (sw_reset_req) begin
            enter(0);
         end else if (m_phase == 1) begin
            if (ls) m_run++;
            else    m_run = 0;
            if (m_run == LF)             enter(2);
            else if (m_since == LT - 1)  enter(0);
            else                         m_since++;
         end else if (!ls) begin
            enter(1);
            if (m_llc < 255) m_llc++;
         end else if (m_phase == 2 && m_since == ND * SD - 1) begin
            enter(3);
         end else begin
            m_since++;
         end
      end
   endtask

   function automatic logic [31:0] pk(input logic p, input logic [2:0] d, input logic r,
                                      input logic [1:0] s, input logic [7:0] l);
      return {17'd0, p, d, r, s, l};
   endfunction

   function automatic logic [31:0] dut_vec();
      return pk(pll_rst, domain_rst, all_ready, seq_state, lock_loss_count);
   endfunction

   // Domain k is held while fewer than k*SD cycles have passed in RELEASE.
   function automatic logic [31:0] model_out();
      logic [ND-1:0] d;
      for (int k = 0; k < ND; k++) d[k] = (m_phase < 2) || (m_phase == 2 && m_since < k * SD);
      return pk(m_phase == 0, d, m_phase == 3, 2'(m_phase), 8'(m_llc));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic wait_state(input logic [1:0] st, input int bound);
      int n;
      n = 0;
      while (seq_state !== st && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", {30'd0, seq_state}, {30'd0, st});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) chk("model_cycle", dut_vec(), model_out());
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w;
      int          exp_llc;
      logic        pe;

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_values", dut_vec(), pk(1'b1, 3'b111, 1'b0, 2'd0, 8'd0));

      // Cold start: rst drops in T0, lock rises in T0+10.
      rst = 1'b0;
      for (int i = 0; i <= 31; i++) begin
         if (i == 10) pll_locked = 1'b1;
         if (i < 3)       w = pk(1'b1, 3'b111, 1'b0, 2'd0, 8'd0);
         else if (i < 16) w = pk(1'b0, 3'b111, 1'b0, 2'd1, 8'd0);
         else if (i < 21) w = pk(1'b0, 3'b110, 1'b0, 2'd2, 8'd0);
         else if (i < 26) w = pk(1'b0, 3'b100, 1'b0, 2'd2, 8'd0);
         else if (i < 31) w = pk(1'b0, 3'b000, 1'b0, 2'd2, 8'd0);
         else             w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd0);
         chk($sformatf("cold_start[%0d]", i), dut_vec(), w);
         @(negedge clk);
      end

      // Software re-run from RUN, then a one-cycle lock glitch inside the filter.
      for (int i = 0; i <= 26; i++) begin
         if (i == 0) sw_reset_req = 1'b1;
         if (i == 1) sw_reset_req = 1'b0;
         if (i == 4) pll_locked = 1'b0;
         if (i == 5) pll_locked = 1'b1;
         if (i < 1)       w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd0);
         else if (i < 4)  w = pk(1'b1, 3'b111, 1'b0, 2'd0, 8'd0);
         else if (i < 11) w = pk(1'b0, 3'b111, 1'b0, 2'd1, 8'd0);
         else if (i < 16) w = pk(1'b0, 3'b110, 1'b0, 2'd2, 8'd0);
         else if (i < 21) w = pk(1'b0, 3'b100, 1'b0, 2'd2, 8'd0);
         else if (i < 26) w = pk(1'b0, 3'b000, 1'b0, 2'd2, 8'd0);
         else             w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd0);
         chk($sformatf("glitch[%0d]", i), dut_vec(), w);
         @(negedge clk);
      end

      // Lock lost in RUN for 3 cycles, then staggered release repeats.
      for (int i = 0; i <= 25; i++) begin
         if (i == 0) pll_locked = 1'b0;
         if (i == 3) pll_locked = 1'b1;
         if (i < 3)       w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd0);
         else if (i < 9)  w = pk(1'b0, 3'b111, 1'b0, 2'd1, 8'd1);
         else if (i < 14) w = pk(1'b0, 3'b110, 1'b0, 2'd2, 8'd1);
         else if (i < 19) w = pk(1'b0, 3'b100, 1'b0, 2'd2, 8'd1);
         else if (i < 24) w = pk(1'b0, 3'b000, 1'b0, 2'd2, 8'd1);
         else             w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd1);
         chk($sformatf("lock_loss[%0d]", i), dut_vec(), w);
         @(negedge clk);
      end

      // Lock held low: PLL pulse every PR+LT cycles, PR cycles wide.
      for (int i = 0; i <= 106; i++) begin
         if (i == 0) pll_locked = 1'b0;
         if (i < 3) begin
            w = pk(1'b0, 3'b000, 1'b1, 2'd3, 8'd1);
         end else begin
            pe = (i >= 53) && (((i - 53) % 53) < 3);
            w  = pk(pe, 3'b111, 1'b0, pe ? 2'd0 : 2'd1, 8'd2);
         end
         chk($sformatf("timeout[%0d]", i), dut_vec(), w);
         @(negedge clk);
      end

      // Software request and lock loss land in the same RELEASE cycle.
      pll_locked = 1'b1;
      wait_state(2'd2, 40);
      pll_locked = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sw_pre", dut_vec(), pk(1'b0, 3'b110, 1'b0, 2'd2, 8'd2));
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      pll_locked   = 1'b1;
      chk("sw_beats_lockloss", dut_vec(), pk(1'b1, 3'b111, 1'b0, 2'd0, 8'd2));

      // Repeated lock losses from RUN drive the counter into saturation.
      exp_llc = 2;
      for (int e = 0; e < 260; e++) begin
         wait_state(2'd3, 60);
         pll_locked = 1'b0;
         @(negedge clk);
         pll_locked = 1'b1;
         @(negedge clk);
         @(negedge clk);
         if (exp_llc < 255) exp_llc++;
         chk($sformatf("llc_event[%0d]", e), {22'd0, seq_state, lock_loss_count},
             {22'd0, 2'd1, 8'(exp_llc)});
      end

      // rst in RELEASE restores every output on the next edge.
      wait_state(2'd2, 30);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_release", dut_vec(), pk(1'b1, 3'b111, 1'b0, 2'd0, 8'd0));
      rst = 1'b0;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
